// File: rtl/bist_pkg.sv
// Shared BIST definitions: analyzer FSM states and default MISR/LFSR constants.
package bist_pkg;

  localparam int unsigned BIST_WIDTH = 16;
  localparam logic [15:0] BIST_POLY  = 16'h002D;  // x^16+x^5+x^3+x^2+1
  localparam logic [15:0] BIST_SEED  = 16'h0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    CMP  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage : bist_pkg

// File: rtl/misr.sv
// Two-input multiple-input signature register with synchronous load of SEED.
module misr
  import bist_pkg::*;
#(
  parameter int unsigned      WIDTH = BIST_WIDTH,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(BIST_POLY),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(BIST_SEED)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic             en,
  input  logic [1:0]       d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] next_c;

  // Galois-style shift with MSB feedback, responses folded into the two LSBs
  always_comb begin
    next_c = {q[WIDTH-2:0], 1'b0} ^ (q[WIDTH-1] ? POLY : '0) ^ {{(WIDTH-2){1'b0}}, d};
  end

  // Signature register: reset/load to SEED, otherwise advance when enabled
  always_ff @(posedge CLK) begin
    if (RST || load) begin
      q <= SEED;
    end else if (en) begin
      q <= next_c;
    end
  end

endmodule : misr

// File: rtl/bist_resp_analyzer.sv
// BIST output response analyzer: compacts CUT responses into a MISR over a
// fixed pattern window and compares the final signature with GOLDEN.
module bist_resp_analyzer
  import bist_pkg::*;
#(
  parameter int unsigned      WIDTH      = BIST_WIDTH,
  parameter logic [WIDTH-1:0] POLY       = WIDTH'(BIST_POLY),
  parameter logic [WIDTH-1:0] SEED       = WIDTH'(BIST_SEED),
  parameter int unsigned      N_PATTERNS = 500,
  parameter int unsigned      SKIP       = 2,
  parameter logic [WIDTH-1:0] GOLDEN     = WIDTH'(16'hA5C3)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             bist_start,
  input  logic             out_synced_d,
  input  logic             out_sync_err_d,
  output logic             bist_end,
  output logic             pass_fail,
  output logic [WIDTH-1:0] signature
);

  localparam int unsigned      CNT_W    = $clog2(SKIP + N_PATTERNS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SKIP + N_PATTERNS - 1);
  localparam logic [CNT_W:0]   SKIP_X   = (CNT_W+1)'(SKIP);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bist_end_d, pass_fail_d;
  logic             misr_load_c, misr_en_c;

  misr #(
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr (
    .CLK  (CLK),
    .RST  (RST),
    .load (misr_load_c),
    .en   (misr_en_c),
    .d    ({out_synced_d, out_sync_err_d}),
    .q    (signature)
  );

  // State, cycle counter and verdict registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bist_end  <= 1'b0;
      pass_fail <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bist_end  <= bist_end_d;
      pass_fail <= pass_fail_d;
    end
  end

  // Next-state, counter, MISR control and verdict logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bist_end_d  = bist_end;
    pass_fail_d = pass_fail;
    misr_load_c = 1'b0;
    misr_en_c   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (bist_start) begin
          state_d     = RUN;
          cnt_d       = '0;
          bist_end_d  = 1'b0;
          pass_fail_d = 1'b0;
          misr_load_c = 1'b1;
        end
      end
      RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        // cnt >= SKIP, written so it stays non-constant when SKIP is 0
        misr_en_c = ({1'b0, cnt_q} + (CNT_W+1)'(1)) > SKIP_X;
        if (cnt_q == CNT_LAST) begin
          state_d = CMP;
        end
      end
      CMP: begin
        pass_fail_d = (signature == GOLDEN);
        bist_end_d  = 1'b1;
        state_d     = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule : bist_resp_analyzer
